// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: bench-side run sequencer for soc_top panel buttons.
// Sequences clear PU -> load program -> start -> wait for settle.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   run_req, skip_load     start a run (IDLE only), bypass load phase
//   abort                  force ERR from any running state
//   pnl_pu_state           PU state, 0 = stopped
//   pnl_input_active       input device busy
//   pnl_output_active      output device busy
//   btn_*                  registered button pulses to soc_top
//   run_busy               high outside IDLE
//   run_done               one-cycle success pulse
//   run_error              sticky error, cleared on next accepted run
//   run_cycles             cycles from CLR entry to DONE/ERR entry
//
// Optional: define SIM_RUN_WATCHDOG_EN to add a per-wait-state timeout.

module sim_run_ctrl #(
    parameter int unsigned PULSE_LEN  = 4,
    parameter logic [15:0] SETTLE_CYC = 16'd255,
    parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run_req,
    input  logic        skip_load,
    input  logic        abort,
    input  logic [2:0]  pnl_pu_state,
    input  logic        pnl_input_active,
    input  logic        pnl_output_active,
    output logic        btn_clear_pu,
    output logic        btn_start_input,
    output logic        btn_start_pulse,
    output logic        btn_stop_input,
    output logic        btn_stop_output,
    output logic        run_busy,
    output logic        run_done,
    output logic        run_error,
    output logic [31:0] run_cycles
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_LEN - 1);

    if (PULSE_LEN == 0 || SETTLE_CYC == 16'd0 || TIMEOUT == 32'd0)
    begin : g_bad_param
        $error("sim_run_ctrl: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_RUN_REQ,
        S_RUN_WAIT,
        S_SETTLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [PW-1:0] pcnt;
    logic [15:0]   qcnt;
    logic          seen;
    logic          skip_q;
    logic          quiet;
    logic          p_end;
    logic          enter;
    logic          active;
    logic          accept;

`ifdef SIM_RUN_WATCHDOG_EN
    logic [31:0]   wd_cnt;
    logic          wd_state;
    assign wd_state = (state == S_LOAD_WAIT) ||
                      (state == S_RUN_WAIT) ||
                      (state == S_SETTLE);
`endif

    assign quiet  = (pnl_pu_state == 3'd0) &&
                    !pnl_input_active && !pnl_output_active;
    assign p_end  = (pcnt == P_LAST);
    assign enter  = (nxt != state);
    assign accept = (state == S_IDLE) && (nxt == S_CLR);
    // run_cycles counts edges taken while in CLR..SETTLE, so the edge
    // entering DONE/ERR is the last one counted.
    assign active = (state != S_IDLE) && (state != S_DONE) &&
                    (state != S_ERR);

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:      if (run_req) nxt = S_CLR;
            S_CLR:       if (p_end) nxt = skip_q ? S_RUN_REQ : S_LOAD_REQ;
            S_LOAD_REQ:  if (p_end) nxt = S_LOAD_WAIT;
            S_LOAD_WAIT: if (seen && !pnl_input_active) nxt = S_RUN_REQ;
            S_RUN_REQ:   if (p_end) nxt = S_RUN_WAIT;
            S_RUN_WAIT:  if (pnl_pu_state != 3'd0) nxt = S_SETTLE;
            S_SETTLE:    if (quiet && qcnt == SETTLE_CYC - 16'd1) nxt = S_DONE;
            S_DONE:      nxt = S_IDLE;
            S_ERR:       if (p_end) nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
`ifdef SIM_RUN_WATCHDOG_EN
        if (wd_state && wd_cnt == TIMEOUT - 32'd1) nxt = S_ERR;
`endif
        // abort beats every other transition, including the watchdog
        if (abort && state != S_IDLE && state != S_ERR) nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= S_IDLE;
            pcnt            <= '0;
            qcnt            <= '0;
            seen            <= 1'b0;
            skip_q          <= 1'b0;
            btn_clear_pu    <= 1'b0;
            btn_start_input <= 1'b0;
            btn_start_pulse <= 1'b0;
            btn_stop_input  <= 1'b0;
            btn_stop_output <= 1'b0;
            run_busy        <= 1'b0;
            run_done        <= 1'b0;
            run_error       <= 1'b0;
            run_cycles      <= '0;
`ifdef SIM_RUN_WATCHDOG_EN
            wd_cnt          <= '0;
`endif
        end else begin
            state <= nxt;
            pcnt  <= (enter || p_end) ? '0 : pcnt + 1'b1;
            qcnt  <= (state == S_SETTLE && quiet && !enter) ?
                     qcnt + 16'd1 : 16'd0;
            seen  <= !enter && (state == S_LOAD_WAIT) &&
                     (seen || pnl_input_active);
`ifdef SIM_RUN_WATCHDOG_EN
            wd_cnt <= (enter || !wd_state) ? 32'd0 : wd_cnt + 32'd1;
`endif
            // buttons and status decode the state being entered
            btn_clear_pu    <= (nxt == S_CLR);
            btn_start_input <= (nxt == S_LOAD_REQ);
            btn_start_pulse <= (nxt == S_RUN_REQ);
            btn_stop_input  <= (nxt == S_ERR);
            btn_stop_output <= (nxt == S_ERR);
            run_busy        <= (nxt != S_IDLE);
            run_done        <= (nxt == S_DONE);

            if (accept) begin
                skip_q     <= skip_load;
                run_error  <= 1'b0;
                run_cycles <= '0;
            end else begin
                if (nxt == S_ERR && state != S_ERR) run_error <= 1'b1;
                if (active && run_cycles != 32'hFFFF_FFFF)
                    run_cycles <= run_cycles + 32'd1;
            end
        end
    end

endmodule
